// File: rtl/neander_pkg.sv
// neander_pkg: opcodes, ALU selects, FSM states and control word for the Neander control unit
package neander_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_AND = 2'b01;
  localparam logic [1:0] ULA_OR  = 2'b10;
  localparam logic [1:0] ULA_NOT = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH_ADDR,
    S_FETCH_READ,
    S_FETCH_LOAD,
    S_DECODE,
    S_OP_READ,
    S_OP_PTR,
    S_DATA_READ,
    S_EXEC,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [1:0] sula;
    logic       ssel_ac;
    logic       ssel_rem;
    logic       scarga_ac;
    logic       scarga_nz;
    logic       scarga_pc;
    logic       sinc_pc;
    logic       scarga_ri;
    logic       scarga_rem;
    logic       smem_read;
    logic       smem_write;
    logic       shalt;
  } ctrl_t;

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JN) || (op == OP_JZ);
  endfunction

  // Conditional jumps only fetch their operand when the branch is taken
  function automatic logic takes_operand(input logic [3:0] op, input logic n, input logic z);
    return (op inside {OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP}) ||
           ((op == OP_JN) && n) || ((op == OP_JZ) && z);
  endfunction

  function automatic logic [1:0] alu_sel(input logic [3:0] op);
    return (op == OP_AND) ? ULA_AND : (op == OP_OR) ? ULA_OR : ULA_ADD;
  endfunction
endpackage

// File: rtl/neander_mem_timer.sv
// neander_mem_timer: read-done pulse generator shared by every memory access state
module neander_mem_timer #(
  parameter int LIM = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ready,
  output logic o_done
);
  logic [1:0] r_cnt;

  assign o_done = i_busy && i_ready && (r_cnt == 2'(LIM));

  // Count cycles spent in the current access, saturating at the limit, cleared between accesses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else r_cnt <= (!i_busy || o_done) ? '0 : ((r_cnt == 2'(LIM)) ? r_cnt : r_cnt + 2'd1);
  end
endmodule

// File: rtl/neander_control.sv
// neander_control: Neander CPU sequencer; define NEANDER_WAIT_EN for emem_ready handshaking
module neander_control
  import neander_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef NEANDER_WAIT_EN
  input  logic       emem_ready,
`endif
  input  logic [3:0] eopcode,
  input  logic       en,
  input  logic       ez,
  output logic [1:0] sula,
  output logic       ssel_ac,
  output logic       ssel_rem,
  output logic       scarga_ac,
  output logic       scarga_nz,
  output logic       scarga_pc,
  output logic       sinc_pc,
  output logic       scarga_ri,
  output logic       scarga_rem,
  output logic       smem_read,
  output logic       smem_write,
  output logic       shalt
);
  state_t r_state, w_next;
  ctrl_t  w_cw;
  logic   w_busy, w_done, w_ready, w_wr_hold;

`ifdef NEANDER_WAIT_EN
  localparam int TLIM = 0;
  assign w_ready   = emem_ready;
  assign w_wr_hold = (r_state == S_EXEC) && (eopcode == OP_STA);
`else
  localparam int TLIM = MEM_LAT - 1;
  assign w_ready   = 1'b1;
  assign w_wr_hold = 1'b0;
`endif

  assign w_busy = (r_state inside {S_FETCH_READ, S_OP_READ, S_DATA_READ}) || w_wr_hold;

  neander_mem_timer #(.LIM(TLIM)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_busy (w_busy),
    .i_ready(w_ready),
    .o_done (w_done)
  );

  // Outputs are forced low while reset is held so an aborted write never reaches memory
  assign {sula, ssel_ac, ssel_rem, scarga_ac, scarga_nz, scarga_pc, sinc_pc,
          scarga_ri, scarga_rem, smem_read, smem_write, shalt} = rst ? '0 : w_cw;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH_ADDR;
    else r_state <= w_next;
  end

  // Next-state and control word; opcode comes from RI, which is stable for the whole instruction
  always_comb begin
    w_next = r_state;
    w_cw   = '0;
    case (r_state)
      S_FETCH_ADDR: begin
        w_cw.scarga_rem = 1'b1;
        w_next = S_FETCH_READ;
      end
      S_FETCH_READ: begin
        w_cw.smem_read = 1'b1;
        w_cw.sinc_pc   = w_done;
        w_next = w_done ? S_FETCH_LOAD : S_FETCH_READ;
      end
      S_FETCH_LOAD: begin
        w_cw.scarga_ri = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (eopcode == OP_HLT) begin
          w_next = S_HALT;
        end else if (eopcode == OP_NOT) begin
          w_cw.sula      = ULA_NOT;
          w_cw.scarga_ac = 1'b1;
          w_cw.scarga_nz = 1'b1;
          w_next = S_FETCH_ADDR;
        end else if (takes_operand(eopcode, en, ez)) begin
          w_cw.scarga_rem = 1'b1;
          w_next = S_OP_READ;
        end else begin
          w_cw.sinc_pc = is_jump(eopcode);
          w_next = S_FETCH_ADDR;
        end
      end
      S_OP_READ: begin
        w_cw.smem_read = 1'b1;
        w_cw.sinc_pc   = w_done;
        w_next = w_done ? S_OP_PTR : S_OP_READ;
      end
      S_OP_PTR: begin
        w_cw.scarga_pc  = is_jump(eopcode);
        w_cw.scarga_rem = !is_jump(eopcode);
        w_cw.ssel_rem   = !is_jump(eopcode);
        w_next = is_jump(eopcode) ? S_FETCH_ADDR : (eopcode == OP_STA) ? S_EXEC : S_DATA_READ;
      end
      S_DATA_READ: begin
        w_cw.smem_read = 1'b1;
        w_next = w_done ? S_EXEC : S_DATA_READ;
      end
      S_EXEC: begin
        w_cw.smem_write = (eopcode == OP_STA);
        w_cw.ssel_ac    = (eopcode == OP_LDA);
        w_cw.scarga_ac  = (eopcode != OP_STA);
        w_cw.scarga_nz  = (eopcode != OP_STA);
        w_cw.sula       = alu_sel(eopcode);
        w_next = (w_wr_hold && !w_done) ? S_EXEC : S_FETCH_ADDR;
      end
      S_HALT: begin
        w_cw.shalt = 1'b1;
      end
      default: w_next = S_FETCH_ADDR;
    endcase
  end
endmodule

// File: tb/tb_neander_control.sv
// tb_neander_control: directed programs run through a bench datapath model around the sequencer
module tb_neander_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b1;
  logic [1:0] sula;
  logic       ssel_ac, ssel_rem, scarga_ac, scarga_nz, scarga_pc, sinc_pc;
  logic       scarga_ri, scarga_rem, smem_read, smem_write, shalt;
  logic [7:0] pc, rem, ri, ac, rdata, nac;
  logic       n, z;
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [12:0] outs;
  int wr_n = 0, acl_n = 0, pcl_n = 0, inc_n = 0, not_n = 0;
  int errors = 0, checks = 0;

`ifdef NEANDER_WAIT_EN
  localparam int X = 3;
  logic emem_ready;
  logic [1:0] wcnt;
  assign emem_ready = (smem_read || smem_write) && (wcnt == 2'd3);
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= '0;
    else wcnt <= ((smem_read || smem_write) && !emem_ready) ? wcnt + 2'd1 : 2'd0;
  end
`else
  localparam int X = 0;
`endif

  neander_control #(.MEM_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef NEANDER_WAIT_EN
    .emem_ready(emem_ready),
`endif
    .eopcode   (ri[7:4]),
    .en        (n),
    .ez        (z),
    .sula      (sula),
    .ssel_ac   (ssel_ac),
    .ssel_rem  (ssel_rem),
    .scarga_ac (scarga_ac),
    .scarga_nz (scarga_nz),
    .scarga_pc (scarga_pc),
    .sinc_pc   (sinc_pc),
    .scarga_ri (scarga_ri),
    .scarga_rem(scarga_rem),
    .smem_read (smem_read),
    .smem_write(smem_write),
    .shalt     (shalt)
  );

  always #5 clk = ~clk;

  assign outs = {sula, ssel_ac, ssel_rem, scarga_ac, scarga_nz, scarga_pc, sinc_pc,
                 scarga_ri, scarga_rem, smem_read, smem_write, shalt};

  function automatic logic [7:0] alu(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return ~a;
    endcase
  endfunction

  assign nac = ssel_ac ? rdata : alu(sula, ac, rdata);

  // Neander datapath and memory driven by the strobes
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 0; rem <= 0; ri <= 0; ac <= 0; n <= 0; z <= 0; rdata <= 0;
      if (ld) mem <= img;
    end else begin
      if (smem_read) rdata <= mem[rem];
      if (smem_write) begin mem[rem] <= ac; wr_n <= wr_n + 1; end
      if (scarga_rem) rem <= ssel_rem ? rdata : pc;
      if (sinc_pc) begin pc <= pc + 8'd1; inc_n <= inc_n + 1; end
      if (scarga_pc) begin pc <= rdata; pcl_n <= pcl_n + 1; end
      if (scarga_ri) ri <= rdata;
      if (scarga_ac) begin ac <= nac; acl_n <= acl_n + 1; end
      if (scarga_nz) begin n <= nac[7]; z <= (nac == 8'h00); end
      if (sula == 2'b11) not_n <= not_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr;
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic do_reset;
    ld = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst_zero", 32'(outs), 32'h0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rst_fetch_addr", 32'(outs), 32'h008);
  endtask

  task automatic run(output int c);
    c = 0;
    do begin
      @(posedge clk);
      #1 c++;
      chk("inv_inc_load_pc", 32'(sinc_pc & scarga_pc), 32'h0);
      chk("inv_read_write", 32'(smem_read & smem_write), 32'h0);
      chk("inv_sula_idle", 32'(scarga_ac ? 2'b00 : sula), 32'h0);
    end while (!shalt && c < 400);
  endtask

  initial begin
    int c, w0, a0, p0, i0, t0;
    // LDA 80, ADD 81, STA 82, HLT
    clr;
    img[8'h00] = 8'h20; img[8'h01] = 8'h80; img[8'h02] = 8'h30; img[8'h03] = 8'h81;
    img[8'h04] = 8'h10; img[8'h05] = 8'h82; img[8'h06] = 8'hF0;
    img[8'h80] = 8'h05; img[8'h81] = 8'h07;
    do_reset;
    w0 = wr_n;
    run(c);
    chk("p1_cycles", c, 27 + 10 * X);
    chk("p1_shalt", 32'(shalt), 32'h1);
    chk("p1_mem82", 32'(mem[8'h82]), 32'h0C);
    chk("p1_ac", 32'(ac), 32'h0C);
    chk("p1_nz", 32'({n, z}), 32'h0);
    chk("p1_writes", wr_n - w0, 1);
    repeat (3) @(posedge clk);
    #1 chk("p1_halt_hold", 32'(outs), 32'h001);
    // LDA 80 (0x80), JN 10 taken
    clr;
    img[8'h00] = 8'h20; img[8'h01] = 8'h80; img[8'h02] = 8'h90; img[8'h03] = 8'h10;
    img[8'h04] = 8'hF0; img[8'h10] = 8'hF0; img[8'h80] = 8'h80;
    do_reset;
    p0 = pcl_n;
    run(c);
    chk("jn_taken_cycles", c, 18 + 6 * X);
    chk("jn_taken_pc", 32'(pc), 32'h11);
    chk("jn_taken_n", 32'(n), 32'h1);
    chk("jn_taken_pcloads", pcl_n - p0, 1);
    // Same with 0x01: skip operand
    img[8'h80] = 8'h01;
    do_reset;
    p0 = pcl_n;
    i0 = inc_n;
    run(c);
    chk("jn_skip_cycles", c, 16 + 5 * X);
    chk("jn_skip_pc", 32'(pc), 32'h05);
    chk("jn_skip_pcloads", pcl_n - p0, 0);
    chk("jn_skip_incs", inc_n - i0, 5);
    // LDA 80 (0x00), JZ 20 taken, NOT, HLT
    clr;
    img[8'h00] = 8'h20; img[8'h01] = 8'h80; img[8'h02] = 8'hA0; img[8'h03] = 8'h20;
    img[8'h04] = 8'hF0; img[8'h20] = 8'h60; img[8'h21] = 8'hF0; img[8'h80] = 8'h00;
    do_reset;
    t0 = not_n;
    run(c);
    chk("jz_not_cycles", c, 22 + 7 * X);
    chk("jz_not_pc", 32'(pc), 32'h22);
    chk("not_ac", 32'(ac), 32'hFF);
    chk("not_nz", 32'({n, z}), 32'h2);
    chk("not_sula_cycles", not_n - t0, 1);
    // Undefined opcodes 7 and B behave as NOP
    clr;
    img[8'h00] = 8'h70; img[8'h01] = 8'hB0; img[8'h02] = 8'hF0;
    do_reset;
    a0 = acl_n;
    p0 = pcl_n;
    run(c);
    chk("nop_cycles", c, 12 + 3 * X);
    chk("nop_pc", 32'(pc), 32'h03);
    chk("nop_acloads", acl_n - a0, 0);
    chk("nop_pcloads", pcl_n - p0, 0);
    // ADD 80 then HLT, one PC increment per fetch
    clr;
    img[8'h00] = 8'h30; img[8'h01] = 8'h80; img[8'h02] = 8'hF0; img[8'h80] = 8'h05;
    do_reset;
    i0 = inc_n;
    run(c);
    chk("add_cycles", c, 12 + 4 * X);
    chk("add_ac", 32'(ac), 32'h05);
    chk("add_incs", inc_n - i0, 3);
    // Reset during STA write cycle aborts it
    clr;
    img[8'h00] = 8'h10; img[8'h01] = 8'h80; img[8'h80] = 8'h55;
    do_reset;
    c = 0;
    while (!smem_write && c < 50) begin
      @(posedge clk);
      #1 c++;
    end
    chk("sta_exec_cycle", c, 6 + 2 * X);
    w0 = wr_n;
    ld = 1'b0;
    rst = 1'b1;
    #1 chk("abort_outs", 32'(outs), 32'h0);
    @(posedge clk);
    #1 chk("abort_mem", 32'(mem[8'h80]), 32'h55);
    chk("abort_writes", wr_n - w0, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("abort_fetch_addr", 32'(outs), 32'h008);
    ld = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
